// File: rtl/cpu_pkg.sv
// Shared types, field positions and helpers for the multi-cycle CPU core family.
package cpu_pkg;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned OP_LSB  = 13;
   localparam int unsigned RD_LSB  = 10;
   localparam int unsigned RS1_LSB = 7;
   localparam int unsigned RS2_LSB = 4;
   localparam int unsigned IMM6_W  = 6;
   localparam int unsigned OFF10_W = 10;

   localparam logic [2:0] REG_PC    = 3'd7;
   localparam logic [2:0] COND_HALT = 3'b111;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_ORR  = 3'b011,
      OP_ADDI = 3'b100,
      OP_LDR  = 3'b101,
      OP_STR  = 3'b110,
      OP_B    = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      COND_AL  = 3'b000,
      COND_EQ  = 3'b001,
      COND_NE  = 3'b010,
      COND_CS  = 3'b011,
      COND_MI  = 3'b100,
      COND_VS  = 3'b101,
      COND_LT  = 3'b110,
      COND_HLT = 3'b111
   } cond_e;

   typedef enum logic [2:0] {
      S_RESET,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALTED
   } state_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

   // Branch condition evaluation against the current flags.
   function automatic logic cond_pass(input cond_e c, input nzcv_t f);
      case (c)
         COND_AL: return 1'b1;
         COND_EQ: return f.z;
         COND_NE: return !f.z;
         COND_CS: return f.c;
         COND_MI: return f.n;
         COND_VS: return f.v;
         COND_LT: return f.n != f.v;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational DATA_W ALU: add/sub via a single adder, plus AND/ORR, with NZCV.
module mc_alu
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  op_e               op,
   output logic [DATA_W-1:0] result,
   output nzcv_t             nzcv
);

   logic              sub;
   logic [DATA_W-1:0] b_eff;
   logic [DATA_W:0]   sum;

   // SUB is A + ~B + 1, so C = 1 means no borrow.
   always_comb begin
      sub    = (op == OP_SUB);
      b_eff  = sub ? ~b : b;
      sum    = {1'b0, a} + {1'b0, b_eff} + (DATA_W+1)'(sub);
      result = sum[DATA_W-1:0];
      case (op)
         OP_AND:  result = a & b;
         OP_ORR:  result = a | b;
         default: ;
      endcase
      nzcv.n = result[DATA_W-1];
      nzcv.z = (result == '0);
      nzcv.c = sum[DATA_W];
      nzcv.v = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
   end

endmodule

// File: rtl/multicycle_cpu_core.sv
// Multi-cycle 16-bit ISA core: one FSM sequences fetch/decode/exec/mem/wb
// against req/ready instruction and data memories.
module multicycle_cpu_core
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ready,
   input  logic [15:0]        imem_rdata,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [ADDR_W-1:0]  dmem_addr,
   output logic [DATA_W-1:0]  dmem_wdata,
   input  logic               dmem_ready,
   input  logic [DATA_W-1:0]  dmem_rdata,
   output logic               retire,
   output logic               halted,
   output logic [3:0]         flags
);

   localparam int unsigned TGT_W = (ADDR_W > OFF10_W) ? ADDR_W : OFF10_W;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, mem_addr_q;
   logic [INSTR_W-1:0]  ir_q;
   logic [DATA_W-1:0]   a_q, b_q, res_q, ld_q;
   nzcv_t               flags_q;
   logic [DATA_W-1:0]   rf_q [8];

   op_e                 op;
   logic [2:0]          rd, rs1, rs2;
   logic [DATA_W-1:0]   imm, r7_val, src_a, src_b, src_d, alu_b, alu_res, wb_val;
   logic [ADDR_W-1:0]   pc_inc, br_tgt;
   nzcv_t               alu_flags;

   assign op     = op_e'(ir_q[OP_LSB +: 3]);
   assign rd     = ir_q[RD_LSB +: 3];
   assign rs1    = ir_q[RS1_LSB +: 3];
   assign rs2    = ir_q[RS2_LSB +: 3];
   assign imm    = DATA_W'(ir_q[IMM6_W-1:0]);
   assign pc_inc = pc_q + ADDR_W'(1);
   assign br_tgt = ADDR_W'(TGT_W'(pc_inc) + TGT_W'($signed(ir_q[OFF10_W-1:0])));

   // Operand selection; R7 reads as PC+1.
   always_comb begin
      r7_val = DATA_W'(pc_inc);
      src_a  = (rs1 == REG_PC) ? r7_val : rf_q[rs1];
      src_b  = (rs2 == REG_PC) ? r7_val : rf_q[rs2];
      src_d  = (rd  == REG_PC) ? r7_val : rf_q[rd];
      alu_b  = (op inside {OP_ADDI, OP_LDR, OP_STR}) ? imm : b_q;
      wb_val = (op == OP_LDR) ? ld_q : res_q;
   end

   mc_alu #(.DATA_W(DATA_W)) u_alu (
      .a      (a_q),
      .b      (alu_b),
      .op     (op),
      .result (alu_res),
      .nzcv   (alu_flags)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_RESET;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET:  state_d = S_FETCH;
         S_FETCH:  if (imem_ready) state_d = S_DECODE;
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (op == OP_LDR || op == OP_STR)      state_d = S_MEM;
            else if (op == OP_B && rd == COND_HALT) state_d = S_HALTED;
            else                                    state_d = S_WB;
         end
         S_MEM:    if (dmem_ready) state_d = S_WB;
         S_WB:     state_d = S_FETCH;
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_RESET;
      endcase
   end

   // Request/status outputs are Moore, decoded from the state alone.
   always_comb begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      retire   = 1'b0;
      halted   = 1'b0;
      case (state_q)
         S_FETCH:  imem_req = 1'b1;
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (op == OP_STR);
         end
         S_WB:     retire = 1'b1;
         S_HALTED: halted = 1'b1;
         default:  ;
      endcase
   end

   assign imem_addr  = pc_q;
   assign dmem_addr  = mem_addr_q;
   assign dmem_wdata = b_q;
   assign flags      = flags_q;

   // Datapath registers, advanced by the current state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= '0;
         ir_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         res_q      <= '0;
         ld_q       <= '0;
         mem_addr_q <= '0;
         flags_q    <= '0;
         for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      end else begin
         case (state_q)
            S_FETCH: if (imem_ready) ir_q <= imem_rdata;
            S_DECODE: begin
               a_q <= src_a;
               b_q <= (op == OP_STR) ? src_d : src_b;
            end
            S_EXEC: begin
               res_q      <= alu_res;
               mem_addr_q <= ADDR_W'(alu_res);
               case (op)
                  OP_ADD, OP_SUB, OP_ADDI: flags_q <= alu_flags;
                  OP_AND, OP_ORR: begin
                     flags_q.n <= alu_flags.n;
                     flags_q.z <= alu_flags.z;
                  end
                  default: ;
               endcase
            end
            S_MEM: if (dmem_ready) ld_q <= dmem_rdata;
            S_WB: begin
               pc_q <= pc_inc;
               case (op)
                  OP_STR: ;
                  OP_B:    if (cond_pass(cond_e'(rd), flags_q)) pc_q <= br_tgt;
                  default: begin
                     if (rd == REG_PC) pc_q     <= ADDR_W'(wb_val);
                     else              rf_q[rd] <= wb_val;
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Directed bench for multicycle_cpu_core with wait-state capable behavioural memories.
module tb_multicycle_cpu_core;
   import cpu_pkg::*;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               imem_req, imem_ready;
   logic [ADDR_W-1:0]  imem_addr;
   logic [15:0]        imem_rdata;
   logic               dmem_req, dmem_we, dmem_ready;
   logic [ADDR_W-1:0]  dmem_addr;
   logic [DATA_W-1:0]  dmem_wdata, dmem_rdata;
   logic               retire, halted;
   logic [3:0]         flags;

   logic [15:0]        imem [256];
   logic [DATA_W-1:0]  dmem [256];
   int                 iwait = 0, dwait = 0;
   int                 icnt = 0, dcnt = 0;
   int                 n_checks = 0, n_pass = 0;

   logic               watch_en = 1'b0;
   logic               exp_we = 1'b0;
   logic [7:0]         exp_daddr = '0, exp_wdata = '0;

   multicycle_cpu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ready (dmem_ready),
      .dmem_rdata (dmem_rdata),
      .retire     (retire),
      .halted     (halted),
      .flags      (flags)
   );

   always #5 clk = ~clk;

   // Memories answer after iwait/dwait request cycles; stores land on the ready edge.
   always @(posedge clk) begin
      if (!imem_req || imem_ready) icnt <= 0; else icnt <= icnt + 1;
      if (!dmem_req || dmem_ready) dcnt <= 0; else dcnt <= dcnt + 1;
      if (dmem_req && dmem_ready && dmem_we) dmem[dmem_addr] <= dmem_wdata;
   end

   assign imem_ready = imem_req && (icnt >= iwait);
   assign imem_rdata = imem[imem_addr];
   assign dmem_ready = dmem_req && (dcnt >= dwait);
   assign dmem_rdata = dmem[dmem_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Data bus must hold steady for the whole access.
   always @(negedge clk) begin
      if (watch_en && dmem_req) begin
         check("dmem_addr stable", 32'(dmem_addr), 32'(exp_daddr));
         check("dmem_we stable", 32'(dmem_we), 32'(exp_we));
         if (exp_we) check("dmem_wdata stable", 32'(dmem_wdata), 32'(exp_wdata));
      end
   end

   function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic [2:0] rs2);
      return {op, rd, rs1, rs2, 4'b0000};
   endfunction

   function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs1, input logic [5:0] imm);
      return {op, rd, rs1, 1'b0, imm};
   endfunction

   function automatic logic [15:0] enc_b(input logic [2:0] cond, input logic [9:0] off);
      return {3'b111, cond, off};
   endfunction

   // Checks the fetch address, then waits for retire and checks the latency.
   task automatic wait_retire(input string tag, input int pc, input int cyc);
      int n = 0;
      @(negedge clk);
      n++;
      check({tag, " fetch addr"}, 32'(imem_addr), 32'(pc));
      while (!retire && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, " retire"}, 32'(retire), 32'd1);
      check({tag, " cycles"}, 32'(n), 32'(cyc));
   endtask

   task automatic wait_halt(input string tag, input int pc);
      int n = 0;
      @(negedge clk);
      n++;
      check({tag, " fetch addr"}, 32'(imem_addr), 32'(pc));
      while (!halted && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, " halted"}, 32'(halted), 32'd1);
      check({tag, " cycles"}, 32'(n), 32'd4);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " imem_req"},   32'(imem_req), 32'd0);
      check({tag, " imem_addr"},  32'(imem_addr), 32'd0);
      check({tag, " dmem_req"},   32'(dmem_req), 32'd0);
      check({tag, " dmem_we"},    32'(dmem_we), 32'd0);
      check({tag, " dmem_addr"},  32'(dmem_addr), 32'd0);
      check({tag, " dmem_wdata"}, 32'(dmem_wdata), 32'd0);
      check({tag, " retire"},     32'(retire), 32'd0);
      check({tag, " halted"},     32'(halted), 32'd0);
      check({tag, " flags"},      32'(flags), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         imem[i] = 16'hFC00;
         dmem[i] <= '0;
      end
      dmem[8'h15] <= 8'hAA;

      imem[0]     = enc_i(OP_ADDI, 3'd1, 3'd0, 6'd5);
      imem[1]     = enc_i(OP_ADDI, 3'd2, 3'd0, 6'd3);
      imem[2]     = enc_r(OP_SUB,  3'd3, 3'd1, 3'd2);
      imem[3]     = enc_r(OP_SUB,  3'd4, 3'd2, 3'd1);
      imem[4]     = enc_b(COND_MI, 10'd2);
      imem[5]     = enc_i(OP_STR,  3'd1, 3'd0, 6'h18);
      imem[6]     = enc_i(OP_STR,  3'd1, 3'd0, 6'h18);
      imem[7]     = enc_i(OP_STR,  3'd1, 3'd0, 6'h10);
      imem[8]     = enc_i(OP_LDR,  3'd5, 3'd0, 6'h10);
      imem[9]     = enc_i(OP_STR,  3'd3, 3'd0, 6'h11);
      imem[10]    = enc_i(OP_STR,  3'd4, 3'd0, 6'h12);
      imem[11]    = enc_i(OP_STR,  3'd5, 3'd0, 6'h13);
      imem[12]    = enc_i(OP_ADDI, 3'd1, 3'd0, 6'h20);
      imem[13]    = enc_r(OP_ADD,  3'd7, 3'd0, 3'd1);
      imem[8'h20] = enc_r(OP_ADD,  3'd6, 3'd7, 3'd0);
      imem[8'h21] = enc_i(OP_STR,  3'd6, 3'd0, 6'h14);
      imem[8'h22] = enc_r(OP_SUB,  3'd2, 3'd0, 3'd1);
      imem[8'h23] = enc_b(COND_EQ, 10'd5);
      imem[8'h24] = enc_b(COND_LT, 10'd1);
      imem[8'h25] = enc_i(OP_STR,  3'd1, 3'd0, 6'h18);

      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;

      wait_retire("addi r1", 0, 4);
      wait_retire("addi r2", 1, 4);
      wait_retire("sub r3", 2, 4);
      check("flags 5-3", 32'(flags), 32'h2);
      wait_retire("sub r4", 3, 4);
      check("flags 3-5", 32'(flags), 32'h8);
      wait_retire("b mi", 4, 4);

      dwait = 3; exp_daddr = 8'h10; exp_we = 1'b1; exp_wdata = 8'h05; watch_en = 1'b1;
      wait_retire("str r1", 7, 8);
      check("store committed", 32'(dmem[8'h10]), 32'h05);
      exp_we = 1'b0;
      wait_retire("ldr r5", 8, 8);
      watch_en = 1'b0; dwait = 0; iwait = 2;
      wait_retire("str r3", 9, 7);
      wait_retire("str r4", 10, 7);
      wait_retire("str r5", 11, 7);
      iwait = 0;
      wait_retire("addi r1", 12, 4);
      wait_retire("add r7", 13, 4);
      wait_retire("add r6", 8'h20, 4);
      check("flags add r6", 32'(flags), 32'h0);
      wait_retire("str r6", 8'h21, 5);
      wait_retire("sub r2", 8'h22, 4);
      check("flags 0-0x20", 32'(flags), 32'h8);
      wait_retire("b eq", 8'h23, 4);
      wait_retire("b lt", 8'h24, 4);
      wait_halt("halt a", 8'h26);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("halted imem_req", 32'(imem_req), 32'd0);
         check("halted retire", 32'(retire), 32'd0);
      end
      check("flags at halt", 32'(flags), 32'h8);
      check("mem r1", 32'(dmem[8'h10]), 32'h05);
      check("mem r3", 32'(dmem[8'h11]), 32'h02);
      check("mem r4", 32'(dmem[8'h12]), 32'hFE);
      check("mem r5", 32'(dmem[8'h13]), 32'h05);
      check("mem r6", 32'(dmem[8'h14]), 32'h21);
      check("skipped store", 32'(dmem[8'h18]), 32'h00);

      rst_n = 1'b0;
      #1;
      check_reset_outputs("halt reset");
      for (int i = 0; i < 256; i++) imem[i] = 16'hFC00;
      imem[0] = enc_i(OP_ADDI, 3'd5, 3'd0, 6'd9);
      imem[1] = enc_i(OP_STR,  3'd5, 3'd0, 6'h16);
      imem[2] = enc_i(OP_LDR,  3'd5, 3'd0, 6'h10);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_retire("b addi r5", 0, 4);
      wait_retire("b str r5", 1, 5);
      dwait = 20;
      begin
         int n = 0;
         while (!dmem_req && n < 10) begin
            @(negedge clk);
            n++;
         end
      end
      check("ldr waiting req", 32'(dmem_req), 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort dmem_req", 32'(dmem_req), 32'd0);
      check("abort retire", 32'(retire), 32'd0);
      check("abort imem_req", 32'(imem_req), 32'd0);
      imem[0] = enc_i(OP_STR, 3'd5, 3'd0, 6'h15);
      imem[1] = 16'hFC00;
      imem[2] = 16'hFC00;
      repeat (2) @(negedge clk);
      dwait = 0;
      rst_n = 1'b1;
      wait_retire("c str r5", 0, 5);
      wait_halt("halt c", 1);
      check("aborted load r5", 32'(dmem[8'h15]), 32'h00);
      check("b store r5", 32'(dmem[8'h16]), 32'h09);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
